tcp_session_ctrl: RTL and testbench
===================================

# tcp_session_ctrl

Session controller that sequences the TCP payload extractor for one followed stream. It arms a session from a config write and drives the source IP and port the extractor matches against. From per-segment header summaries it tracks the expected sequence number, classifies each segment as in-order, gap (loss) or duplicate, and gates the extractor's payload bytes onto a clean output stream. It sits between the extractor and the downstream payload consumer and status logic.

## Interface
- ALLOW_MIDSTREAM, 0: when 1, a non-SYN header in sWAIT_SYN is used as the sync point.
- COUNT_W, 8: width of the saturating gap and duplicate counters.
- CLOCK  in  1  rising-edge clock.
- RESETn  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  arm strobe; latches cfg_ip and cfg_port.
- cfg_ip  in  32  source IP to follow.
- cfg_port  in  16  source TCP port to follow.
- cfg_abort  in  1  disarm strobe.
- tcp_src_ip  out  32  match IP driven to the extractor.
- tcp_src_port  out  16  match port driven to the extractor.
- hdr_valid  in  1  one-cycle strobe; a matching TCP header has been parsed.
- hdr_seq  in  32  segment sequence number.
- hdr_len  in  16  segment payload length in bytes.
- hdr_syn  in  1  SYN flag.
- hdr_fin  in  1  FIN flag.
- hdr_rst  in  1  RST flag.
- pld_valid  in  1  payload byte strobe from the extractor.
- pld_data  in  8  payload byte.
- out_valid  out  1  forwarded payload byte valid.
- out_data  out  8  forwarded payload byte.
- out_newpkt  out  1  high with the first forwarded byte of each accepted segment.
- state  out  2  0=sIDLE, 1=sWAIT_SYN, 2=sSTREAM, 3=sCLOSED.
- exp_seq  out  32  next expected sequence number.
- gapped  out  1  sticky; a loss gap has occurred since arming.
- gap_count  out  COUNT_W  saturating count of gap segments.
- dup_count  out  COUNT_W  saturating count of dropped duplicate segments.

## Operation
- Reset: every output is 0 and state is sIDLE. Internal `accept` and `remain` are cleared.
- cfg_abort, in any state: go to sIDLE and clear `accept`. cfg_abort wins over a simultaneous cfg_valid.
- cfg_valid, in any state: go to sWAIT_SYN. Latch tcp_src_ip and tcp_src_port. Clear exp_seq, gapped, gap_count, dup_count and `accept`.
- sIDLE: ignore hdr_valid and pld_valid.
- sWAIT_SYN, on hdr_valid:
  - hdr_syn=1: set exp_seq = hdr_seq + 1 + hdr_len and go to sSTREAM.
  - hdr_syn=0 with ALLOW_MIDSTREAM=1: sync as in-order. Set exp_seq = hdr_seq + hdr_len + hdr_fin, go to sSTREAM and accept the payload.
  - Otherwise: drop the segment.
- sSTREAM, on hdr_valid, with d = hdr_seq − exp_seq (mod 2^32):
  - hdr_rst=1: go to sCLOSED and drop the segment.
  - d=0 (in-order): accept. Set exp_seq += hdr_len + hdr_fin. If hdr_fin=1, go to sCLOSED; the payload is still forwarded.
  - d≠0, d[31]=0 (gap): set gapped=1 and increment gap_count. Resync exp_seq = hdr_seq + hdr_len + hdr_fin and accept. A FIN goes to sCLOSED.
  - d[31]=1 (duplicate or retransmit): drop the segment, increment dup_count, leave exp_seq unchanged.
- sCLOSED: ignore hdr_valid. A payload already accepted completes. Only cfg_valid or cfg_abort leaves this state.
- Gating on accept: `accept`=1 and `remain`=hdr_len. If hdr_len=0, `accept` stays 0.
- Payload bytes:
  - Each pld_valid with `accept`=1 forwards the byte and decrements `remain`. `accept` clears when `remain` reaches 0.
  - Bytes beyond hdr_len are dropped.
  - pld_valid with `accept`=0 is dropped.
- A new hdr_valid discards any unfinished `remain` of the previous segment.
- Arithmetic: all sequence math is 32-bit modulo 2^32. hdr_len is zero-extended. Counters saturate at all-ones.

## Timing
- State, exp_seq, counters and gapped update on the clock edge after hdr_valid.
- A pld_valid coincident with hdr_valid is dropped. The extractor presents headers at least 1 cycle before payload.
- out_valid, out_data and out_newpkt are registered, 1-cycle latency from pld_valid. out_newpkt is asserted only with the first forwarded byte of a segment.
- tcp_src_ip and tcp_src_port update on the edge after cfg_valid.
- Reset asserted mid-segment clears outputs immediately; no partial byte is emitted after reset.

## Test plan
- Clean stream: arm with 10.0.0.1:80, send SYN seq=0x1000 len=0, then segments seq=0x1001 len=4 and seq=0x1005 len=3.
  - Expect 7 bytes out, out_newpkt on bytes 1 and 5, exp_seq=0x1008, gapped=0.
- Gap: in sSTREAM with exp_seq=0x2000, send seq=0x2010 len=2.
  - Expect both bytes forwarded, gapped=1, gap_count=1, exp_seq=0x2012.
- Duplicate: with exp_seq=0x2012, send seq=0x2000 len=5.
  - Expect no out_valid, dup_count=1, exp_seq unchanged.
- Wrap-around: exp_seq=0xFFFFFFFE, send seq=0xFFFFFFFE len=4.
  - Expect 4 bytes forwarded, exp_seq=0x00000002, gapped=0.
- FIN/RST:
  - In-order FIN seq=exp len=2: expect 2 bytes out, state=3, exp_seq advanced by 3.
  - RST: expect state=3, no bytes.
  - Later cfg_valid: expect state=1, all counters cleared.
- Midstream and abort:
  - ALLOW_MIDSTREAM=1, first header non-SYN seq=0x500 len=1: expect byte forwarded, state=2, exp_seq=0x501.
  - cfg_abort with cfg_valid in the same cycle: expect state=0.

Source files
------------

// File: rtl/tcp_session_ctrl.sv
// tcp_session_ctrl
//    Follows one TCP stream for the payload extractor. A config write arms
//    the session and publishes the source IP/port the extractor matches on.
//    Per-segment header summaries advance the expected sequence number and
//    classify each segment as in-order, gap or duplicate. Accepted payload
//    bytes go out as a clean registered byte stream.
//
// Ports
//    CLOCK, RESETn                    clock, async active-low reset
//    cfg_valid/cfg_ip/cfg_port        arm strobe and the endpoint to follow
//    cfg_abort                        disarm strobe (wins over cfg_valid)
//    tcp_src_ip/tcp_src_port          latched match endpoint for the extractor
//    hdr_valid/seq/len/syn/fin/rst    one-cycle header summary
//    pld_valid/pld_data               payload bytes from the extractor
//    out_valid/out_data/out_newpkt    forwarded payload, 1-cycle latency
//    state, exp_seq, gapped,
//    gap_count, dup_count             session status
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | S_IDLE     : disarmed, headers and payload ignored
//   1   | S_WAIT_SYN : armed, waiting for a sync point (SYN or midstream)
//   2   | S_STREAM   : tracking exp_seq, classifying segments
//   3   | S_CLOSED   : FIN/RST seen, in-flight payload drains, rest ignored

module tcp_session_ctrl #(
   parameter bit ALLOW_MIDSTREAM = 1'b0,
   parameter int COUNT_W         = 8
) (
   input  logic               CLOCK,
   input  logic               RESETn,
   input  logic               cfg_valid,
   input  logic [31:0]        cfg_ip,
   input  logic [15:0]        cfg_port,
   input  logic               cfg_abort,
   output logic [31:0]        tcp_src_ip,
   output logic [15:0]        tcp_src_port,
   input  logic               hdr_valid,
   input  logic [31:0]        hdr_seq,
   input  logic [15:0]        hdr_len,
   input  logic               hdr_syn,
   input  logic               hdr_fin,
   input  logic               hdr_rst,
   input  logic               pld_valid,
   input  logic [7:0]         pld_data,
   output logic               out_valid,
   output logic [7:0]         out_data,
   output logic               out_newpkt,
   output logic [1:0]         state,
   output logic [31:0]        exp_seq,
   output logic               gapped,
   output logic [COUNT_W-1:0] gap_count,
   output logic [COUNT_W-1:0] dup_count
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_SYN = 2'd1;
   localparam logic [1:0] S_STREAM   = 2'd2;
   localparam logic [1:0] S_CLOSED   = 2'd3;

   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

   logic [1:0]         state_q,   state_d;
   logic [31:0]        exp_seq_q, exp_seq_d;
   logic               gapped_q,  gapped_d;
   logic [COUNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [COUNT_W-1:0] dup_cnt_q, dup_cnt_d;
   logic [31:0]        ip_q,      ip_d;
   logic [15:0]        port_q,    port_d;
   logic               accept_q,  accept_d;
   logic [15:0]        remain_q,  remain_d;
   logic               first_q,   first_d;
   logic               ovalid_q,  ovalid_d;
   logic [7:0]         odata_q,   odata_d;
   logic               onew_q,    onew_d;

   logic [31:0] diff;
   logic [31:0] len32;
   logic [31:0] fin32;
   logic        fwd;
   logic        take;

   always_comb begin
      state_d   = state_q;
      exp_seq_d = exp_seq_q;
      gapped_d  = gapped_q;
      gap_cnt_d = gap_cnt_q;
      dup_cnt_d = dup_cnt_q;
      ip_d      = ip_q;
      port_d    = port_q;
      accept_d  = accept_q;
      remain_d  = remain_q;
      first_d   = first_q;
      ovalid_d  = 1'b0;
      odata_d   = odata_q;
      onew_d    = 1'b0;
      take      = 1'b0;

      diff  = hdr_seq - exp_seq_q;
      len32 = {16'h0000, hdr_len};
      fin32 = {31'h0, hdr_fin};

      // A byte arriving alongside a header or a config strobe belongs to no
      // valid segment, so it is never forwarded.
      fwd = pld_valid & accept_q & ~hdr_valid & ~cfg_valid & ~cfg_abort;

      if (fwd) begin
         ovalid_d = 1'b1;
         odata_d  = pld_data;
         onew_d   = first_q;
         first_d  = 1'b0;
         remain_d = remain_q - 16'd1;
         if (remain_q == 16'd1) begin
            accept_d = 1'b0;
         end
      end

      if (hdr_valid) begin
         case (state_q)
            S_WAIT_SYN: begin
               accept_d = 1'b0;
               if (hdr_syn) begin
                  exp_seq_d = hdr_seq + 32'd1 + len32;
                  state_d   = S_STREAM;
               end else if (ALLOW_MIDSTREAM) begin
                  exp_seq_d = hdr_seq + len32 + fin32;
                  state_d   = S_STREAM;
                  take      = 1'b1;
               end
            end
            S_STREAM: begin
               accept_d = 1'b0;
               if (hdr_rst) begin
                  state_d = S_CLOSED;
               end else if (!diff[31]) begin
                  // d == 0 is in-order; any other forward distance is a loss
                  // gap that resyncs onto this segment.
                  if (diff != 32'd0) begin
                     gapped_d = 1'b1;
                     if (gap_cnt_q != CNT_MAX) begin
                        gap_cnt_d = gap_cnt_q + CNT_ONE;
                     end
                  end
                  exp_seq_d = hdr_seq + len32 + fin32;
                  take      = 1'b1;
                  if (hdr_fin) begin
                     state_d = S_CLOSED;
                  end
               end else begin
                  if (dup_cnt_q != CNT_MAX) begin
                     dup_cnt_d = dup_cnt_q + CNT_ONE;
                  end
               end
            end
            default: ;
         endcase
      end

      if (take) begin
         accept_d = (hdr_len != 16'd0);
         remain_d = hdr_len;
         first_d  = 1'b1;
      end

      if (cfg_abort) begin
         state_d  = S_IDLE;
         accept_d = 1'b0;
      end else if (cfg_valid) begin
         state_d   = S_WAIT_SYN;
         ip_d      = cfg_ip;
         port_d    = cfg_port;
         exp_seq_d = 32'd0;
         gapped_d  = 1'b0;
         gap_cnt_d = '0;
         dup_cnt_d = '0;
         accept_d  = 1'b0;
      end
   end

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= S_IDLE;
         exp_seq_q <= 32'd0;
         gapped_q  <= 1'b0;
         gap_cnt_q <= '0;
         dup_cnt_q <= '0;
         ip_q      <= 32'd0;
         port_q    <= 16'd0;
         accept_q  <= 1'b0;
         remain_q  <= 16'd0;
         first_q   <= 1'b0;
         ovalid_q  <= 1'b0;
         odata_q   <= 8'd0;
         onew_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_seq_q <= exp_seq_d;
         gapped_q  <= gapped_d;
         gap_cnt_q <= gap_cnt_d;
         dup_cnt_q <= dup_cnt_d;
         ip_q      <= ip_d;
         port_q    <= port_d;
         accept_q  <= accept_d;
         remain_q  <= remain_d;
         first_q   <= first_d;
         ovalid_q  <= ovalid_d;
         odata_q   <= odata_d;
         onew_q    <= onew_d;
      end
   end

   assign tcp_src_ip   = ip_q;
   assign tcp_src_port = port_q;
   assign out_valid    = ovalid_q;
   assign out_data     = odata_q;
   assign out_newpkt   = onew_q;
   assign state        = state_q;
   assign exp_seq      = exp_seq_q;
   assign gapped       = gapped_q;
   assign gap_count    = gap_cnt_q;
   assign dup_count    = dup_cnt_q;

endmodule

// File: tb/tb_tcp_session_ctrl.sv
module tb_tcp_session_ctrl;

   logic        CLOCK = 1'b0;
   logic        RESETn = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [31:0] cfg_ip = 32'd0;
   logic [15:0] cfg_port = 16'd0;
   logic        cfg_abort = 1'b0;
   logic        hdr_valid = 1'b0;
   logic [31:0] hdr_seq = 32'd0;
   logic [15:0] hdr_len = 16'd0;
   logic        hdr_syn = 1'b0;
   logic        hdr_fin = 1'b0;
   logic        hdr_rst = 1'b0;
   logic        pld_valid = 1'b0;
   logic [7:0]  pld_data = 8'd0;

   logic [31:0] a_ip;
   logic [15:0] a_port;
   logic        a_ov, a_nw, a_gp;
   logic [7:0]  a_od, a_gc, a_dc;
   logic [1:0]  a_st;
   logic [31:0] a_es;

   logic [31:0] m_ip;
   logic [15:0] m_port;
   logic        m_ov, m_nw, m_gp;
   logic [7:0]  m_od, m_gc, m_dc;
   logic [1:0]  m_st;
   logic [31:0] m_es;

   always #5 CLOCK = ~CLOCK;

   tcp_session_ctrl #(.ALLOW_MIDSTREAM(1'b0), .COUNT_W(8)) dut (
      .CLOCK(CLOCK), .RESETn(RESETn),
      .cfg_valid(cfg_valid), .cfg_ip(cfg_ip), .cfg_port(cfg_port), .cfg_abort(cfg_abort),
      .tcp_src_ip(a_ip), .tcp_src_port(a_port),
      .hdr_valid(hdr_valid), .hdr_seq(hdr_seq), .hdr_len(hdr_len),
      .hdr_syn(hdr_syn), .hdr_fin(hdr_fin), .hdr_rst(hdr_rst),
      .pld_valid(pld_valid), .pld_data(pld_data),
      .out_valid(a_ov), .out_data(a_od), .out_newpkt(a_nw),
      .state(a_st), .exp_seq(a_es), .gapped(a_gp),
      .gap_count(a_gc), .dup_count(a_dc)
   );

   tcp_session_ctrl #(.ALLOW_MIDSTREAM(1'b1), .COUNT_W(8)) dut_mid (
      .CLOCK(CLOCK), .RESETn(RESETn),
      .cfg_valid(cfg_valid), .cfg_ip(cfg_ip), .cfg_port(cfg_port), .cfg_abort(cfg_abort),
      .tcp_src_ip(m_ip), .tcp_src_port(m_port),
      .hdr_valid(hdr_valid), .hdr_seq(hdr_seq), .hdr_len(hdr_len),
      .hdr_syn(hdr_syn), .hdr_fin(hdr_fin), .hdr_rst(hdr_rst),
      .pld_valid(pld_valid), .pld_data(pld_data),
      .out_valid(m_ov), .out_data(m_od), .out_newpkt(m_nw),
      .state(m_st), .exp_seq(m_es), .gapped(m_gp),
      .gap_count(m_gc), .dup_count(m_dc)
   );

   // captured output bytes: {newpkt, data}
   logic [8:0] cap_q[$];
   int         mid_bytes = 0;

   always @(negedge CLOCK) begin
      if (a_ov) cap_q.push_back({a_nw, a_od});
      if (m_ov) mid_bytes++;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic arm(input logic [31:0] ip, input logic [15:0] port);
      cfg_valid = 1'b1; cfg_ip = ip; cfg_port = port;
      @(negedge CLOCK);
      cfg_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] seq, input logic [15:0] len,
                           input logic syn, input logic fin, input logic rst);
      hdr_valid = 1'b1; hdr_seq = seq; hdr_len = len;
      hdr_syn = syn; hdr_fin = fin; hdr_rst = rst;
      @(negedge CLOCK);
      hdr_valid = 1'b0; hdr_syn = 1'b0; hdr_fin = 1'b0; hdr_rst = 1'b0;
   endtask

   task automatic send_pld(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         pld_valid = 1'b1; pld_data = base + 8'(i);
         @(negedge CLOCK);
      end
      pld_valid = 1'b0;
   endtask

   task automatic clear_cap();
      tick(2);
      cap_q.delete();
      mid_bytes = 0;
   endtask

   int n_new;

   initial begin
      tick(2);
      chk("rst_state",   32'(a_st), 32'd0);
      chk("rst_exp_seq", a_es, 32'd0);
      chk("rst_src_ip",  a_ip, 32'd0);
      chk("rst_out_vld", 32'(a_ov), 32'd0);
      chk("rst_gap_cnt", 32'(a_gc), 32'd0);
      RESETn = 1'b1;
      tick(1);

      // clean stream
      arm(32'h0A000001, 16'd80);
      chk("arm_ip",    a_ip, 32'h0A000001);
      chk("arm_port",  32'(a_port), 32'd80);
      chk("arm_state", 32'(a_st), 32'd1);
      clear_cap();
      send_hdr(32'h1000, 16'd0, 1'b1, 1'b0, 1'b0);
      chk("syn_state", 32'(a_st), 32'd2);
      chk("syn_exp",   a_es, 32'h1001);
      send_hdr(32'h1001, 16'd4, 1'b0, 1'b0, 1'b0);
      send_pld(4, 8'hA0);
      send_hdr(32'h1005, 16'd3, 1'b0, 1'b0, 1'b0);
      send_pld(4, 8'hB0);   // one byte past hdr_len must be dropped
      tick(2);
      chk("clean_bytes", 32'(cap_q.size()), 32'd7);
      n_new = 0;
      foreach (cap_q[i]) if (cap_q[i][8]) n_new++;
      chk("clean_newpkt_cnt", 32'(n_new), 32'd2);
      if (cap_q.size() == 7) begin
         chk("clean_b0",  32'(cap_q[0]), 32'h1A0);
         chk("clean_b3",  32'(cap_q[3]), 32'h0A3);
         chk("clean_b4",  32'(cap_q[4]), 32'h1B0);
         chk("clean_b6",  32'(cap_q[6]), 32'h0B2);
      end
      chk("clean_exp",    a_es, 32'h1008);
      chk("clean_gapped", 32'(a_gp), 32'd0);

      // gap
      arm(32'h0A000001, 16'd80);
      send_hdr(32'h1FFF, 16'd0, 1'b1, 1'b0, 1'b0);
      chk("gap_pre_exp", a_es, 32'h2000);
      clear_cap();
      send_hdr(32'h2010, 16'd2, 1'b0, 1'b0, 1'b0);
      send_pld(2, 8'h10);
      tick(2);
      chk("gap_bytes",  32'(cap_q.size()), 32'd2);
      chk("gap_gapped", 32'(a_gp), 32'd1);
      chk("gap_cnt",    32'(a_gc), 32'd1);
      chk("gap_exp",    a_es, 32'h2012);

      // duplicate
      clear_cap();
      send_hdr(32'h2000, 16'd5, 1'b0, 1'b0, 1'b0);
      send_pld(5, 8'h20);
      tick(2);
      chk("dup_bytes",   32'(cap_q.size()), 32'd0);
      chk("dup_cnt",     32'(a_dc), 32'd1);
      chk("dup_exp",     a_es, 32'h2012);
      chk("dup_gap_cnt", 32'(a_gc), 32'd1);

      // wrap-around
      arm(32'h0A000001, 16'd80);
      send_hdr(32'hFFFFFFFD, 16'd0, 1'b1, 1'b0, 1'b0);
      chk("wrap_pre_exp", a_es, 32'hFFFFFFFE);
      clear_cap();
      send_hdr(32'hFFFFFFFE, 16'd4, 1'b0, 1'b0, 1'b0);
      send_pld(4, 8'h30);
      tick(2);
      chk("wrap_bytes",  32'(cap_q.size()), 32'd4);
      chk("wrap_exp",    a_es, 32'h00000002);
      chk("wrap_gapped", 32'(a_gp), 32'd0);

      // in-order FIN
      clear_cap();
      send_hdr(32'h00000002, 16'd2, 1'b0, 1'b1, 1'b0);
      chk("fin_state", 32'(a_st), 32'd3);
      send_pld(2, 8'h40);
      tick(2);
      chk("fin_bytes", 32'(cap_q.size()), 32'd2);
      chk("fin_exp",   a_es, 32'h00000005);
      clear_cap();
      send_hdr(32'h00000005, 16'd1, 1'b0, 1'b0, 1'b0);
      send_pld(1, 8'h50);
      tick(2);
      chk("closed_bytes", 32'(cap_q.size()), 32'd0);
      chk("closed_exp",   a_es, 32'h00000005);

      // RST after building up counters, then re-arm clears them
      arm(32'h0A000002, 16'd443);
      send_hdr(32'h100, 16'd0, 1'b1, 1'b0, 1'b0);
      send_hdr(32'h050, 16'd1, 1'b0, 1'b0, 1'b0);
      send_hdr(32'h200, 16'd0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_dup", 32'(a_dc), 32'd1);
      chk("pre_rst_gap", 32'(a_gc), 32'd1);
      clear_cap();
      send_hdr(32'h200, 16'd3, 1'b0, 1'b0, 1'b1);
      send_pld(3, 8'h60);
      tick(2);
      chk("rst_seg_state", 32'(a_st), 32'd3);
      chk("rst_seg_bytes", 32'(cap_q.size()), 32'd0);
      arm(32'h0A000003, 16'd22);
      chk("rearm_state",  32'(a_st), 32'd1);
      chk("rearm_gap",    32'(a_gc), 32'd0);
      chk("rearm_dup",    32'(a_dc), 32'd0);
      chk("rearm_gapped", 32'(a_gp), 32'd0);
      chk("rearm_exp",    a_es, 32'd0);
      chk("rearm_port",   32'(a_port), 32'd22);

      // midstream sync: only the ALLOW_MIDSTREAM instance syncs
      clear_cap();
      send_hdr(32'h500, 16'd1, 1'b0, 1'b0, 1'b0);
      send_pld(1, 8'h77);
      tick(2);
      chk("mid_state",     32'(m_st), 32'd2);
      chk("mid_exp",       m_es, 32'h501);
      chk("mid_bytes",     32'(mid_bytes), 32'd1);
      chk("nomid_state",   32'(a_st), 32'd1);
      chk("nomid_bytes",   32'(cap_q.size()), 32'd0);

      // abort beats simultaneous arm
      cfg_abort = 1'b1;
      arm(32'h0A000004, 16'd1);
      cfg_abort = 1'b0;
      chk("abort_state",     32'(a_st), 32'd0);
      chk("abort_mid_state", 32'(m_st), 32'd0);

      // duplicate counter saturates at all-ones
      arm(32'h0A000001, 16'd80);
      send_hdr(32'h1000, 16'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 260; i++) send_hdr(32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
      chk("dup_sat", 32'(a_dc), 32'd255);

      // reset mid-segment clears outputs immediately
      send_hdr(32'h1001, 16'd4, 1'b0, 1'b0, 1'b0);
      send_pld(1, 8'h88);
      pld_valid = 1'b1; pld_data = 8'h89;
      @(posedge CLOCK);
      #1;
      chk("pre_reset_ov", 32'(a_ov), 32'd1);
      RESETn = 1'b0;
      #1;
      chk("async_rst_ov",    32'(a_ov), 32'd0);
      chk("async_rst_state", 32'(a_st), 32'd0);
      chk("async_rst_exp",   a_es, 32'd0);
      pld_valid = 1'b0;
      tick(2);
      RESETn = 1'b1;
      tick(2);
      chk("post_rst_ov", 32'(a_ov), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
